// File: rtl/memory_cycle.sv
// memory_cycle: pipeline M stage with word data memory, misalign detection and the M/W register
module memory_cycle #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          mis;
  assign idx = ALU_ResultM[AW+1:2];
  assign mis = (MemWriteM | ResultSrcM) & (ALU_ResultM[1:0] != 2'b00);
  // memory is deliberately left out of reset so it maps to LUT RAM
  always_ff @(posedge clk)
    if (MemWriteM && !mis && rst) mem[idx] <= WriteDataM;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
      MisalignW   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~(ResultSrcM & mis);
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= mem[idx];
      MisalignW   <= mis;
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed vector table plus hand sequences for reset behaviour
module tb_memory_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  int n_err = 0;
  int n_chk = 0;

  memory_cycle #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc, wd, alu;
    logic        e_rw, e_rs, e_mis, c_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
    chk({tag, " ResultSrcW"}, {31'd0, ResultSrcW}, 32'd0);
    chk({tag, " RD_W"}, {27'd0, RD_W}, 32'd0);
    chk({tag, " PCPlus4W"}, PCPlus4W, 32'd0);
    chk({tag, " ALU_ResultW"}, ALU_ResultW, 32'd0);
    chk({tag, " ReadDataW"}, ReadDataW, 32'd0);
    chk({tag, " MisalignW"}, {31'd0, MisalignW}, 32'd0);
  endtask

  initial begin
    //          rw    mw    rs    rd     pc          wd             alu           e_rw  e_rs  e_mis c_rd  e_data
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, 32'h10,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 5'd5, 32'h104, 32'h0,        32'h10,   1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd3, 32'h104, 32'h0,        32'h8,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h108, 32'h11111111, 32'h20,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h10C, 32'h22222222, 32'h22,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'd7, 32'h110, 32'h0,        32'h20,   1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'd8, 32'h114, 32'h0,        32'h31,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h118, 32'hCAFEF00D, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd9, 32'h11C, 32'h0,        32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,   32'h0,        32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd0, 32'h120, 32'h55AA55AA, 32'h10,   1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 5'd2, 32'h124, 32'h0,        32'h10,   1'b1, 1'b1, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 5'd6, 32'h128, 32'h99999999, 32'h13,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 5'd2, 32'h12C, 32'h0,        32'h10,   1'b1, 1'b1, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h130, 32'hA5A5A5A5, 32'hFFC,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'h134, 32'h0,       32'h1FFC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h4, 32'h12345678, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF0004, 32'hBAD0BAD0, 32'h0);
    #1 chk_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    chk_zero("held reset");
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h8, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset no store", ReadDataW, 32'h12345678);
    chk("reset release RD_W", {27'd0, RD_W}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].pc, vecs[i].wd, vecs[i].alu);
      @(negedge clk);
      chk($sformatf("v%0d RegWriteW", i), {31'd0, RegWriteW}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d ResultSrcW", i), {31'd0, ResultSrcW}, {31'd0, vecs[i].e_rs});
      chk($sformatf("v%0d MisalignW", i), {31'd0, MisalignW}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d RD_W", i), {27'd0, RD_W}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d PCPlus4W", i), PCPlus4W, vecs[i].pc);
      chk($sformatf("v%0d ALU_ResultW", i), ALU_ResultW, vecs[i].alu);
      if (vecs[i].c_rd) chk($sformatf("v%0d ReadDataW", i), ReadDataW, vecs[i].e_data);
    end

    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h77777777, 32'h40);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h204, 32'h0, 32'h40);
    @(negedge clk);
    chk("mid pre ReadDataW", ReadDataW, 32'h77777777);
    chk("mid pre RegWriteW", {31'd0, RegWriteW}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h208, 32'h88888888, 32'h40);
    #2 rst = 1'b0;
    #1 chk_zero("mid-cycle reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h20C, 32'h0, 32'h40);
    @(negedge clk);
    chk("mid post ReadDataW", ReadDataW, 32'h77777777);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the 5-stage RISC-V pipeline. Consumes the E/M pipeline register outputs of `execute_cycle` and performs word loads and stores against a local data memory. Registers the results into the M/W pipeline register that feeds the writeback stage. Also flags misaligned accesses and suppresses the corresponding stores.

## Interface
Parameters:
- `DEPTH`, 1024, data memory size in 32-bit words; power of two, at least 4.
- `AW`, `$clog2(DEPTH)`, word-index width (localparam, not overridable).

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegWriteM`  in  1  the instruction writes the register file.
- `MemWriteM`  in  1  store request.
- `ResultSrcM`  in  1  1 = load (writeback selects memory data), 0 = ALU result.
- `RD_M`  in  5  destination register index.
- `PCPlus4M`  in  32  PC+4 of the instruction.
- `WriteDataM`  in  32  store data (rs2).
- `ALU_ResultM`  in  32  effective byte address for memory ops; ALU result otherwise.
- `RegWriteW`  out  1  registered `RegWriteM`, forced to 0 on a misaligned load.
- `ResultSrcW`  out  1  registered `ResultSrcM`.
- `RD_W`  out  5  registered `RD_M`.
- `PCPlus4W`  out  32  registered `PCPlus4M`.
- `ALU_ResultW`  out  32  registered `ALU_ResultM`.
- `ReadDataW`  out  32  registered memory read data.
- `MisalignW`  out  1  registered flag: memory access with address[1:0] != 0.

## Operation
- Word index is `ALU_ResultM[AW+1:2]`. Upper address bits are ignored, so the address wraps modulo `DEPTH*4` bytes.
- Misaligned condition: `mis = (MemWriteM | ResultSrcM) & (ALU_ResultM[1:0] != 0)`.
- **Store:** if `MemWriteM & ~mis & rst`, then `mem[idx] <= WriteDataM` on the rising edge. A misaligned store writes nothing.
- **Read:** `mem[idx]` is read combinationally every cycle, regardless of `ResultSrcM`.
- **M/W register**, updated every rising edge when `rst = 1`:
  - `ReadDataW <= mem[idx]`, using the pre-write contents.
  - `RegWriteW <= RegWriteM & ~(ResultSrcM & mis)`.
  - `MisalignW <= mis`.
  - All other W outputs copy their M inputs.
- **Reset:**
  - `rst = 0` asynchronously clears every W output to 0.
  - While `rst = 0`, no store occurs.
  - Memory contents are not cleared by reset; they are undefined until written.
- **Same-cycle store and load:** a store and a load to the same word in the same cycle is not possible (one instruction per stage). If `MemWriteM` and `ResultSrcM` are both 1, the store executes and `ReadDataW` carries the old word.
- **Hazards:** no stalls or flush ports. Hazard handling lives upstream; a bubble is presented as all-zero M inputs.

## Timing
- Latency from M inputs to W outputs: 1 cycle.
- Store is visible to a load presented in the next cycle: a store in cycle N, then a load to the same word in cycle N+1, gives the new data on `ReadDataW` after edge N+1.
- Read path is combinational from `ALU_ResultM` to the `ReadDataW` D-input, so the memory maps to distributed/LUT RAM.
- Reset assertion takes effect immediately, with no clock required. On deassertion, the first capture happens at the next rising edge.

## Test plan
- **Reset:** hold `rst = 0` with non-zero inputs for 2 cycles. Required: all W outputs are 0 and no store occurs. Release reset, then store and load address 0x0 to check.
- **Store then load:**
  - Cycle 1: `MemWriteM = 1`, `ALU_ResultM = 0x10`, `WriteDataM = 0xDEADBEEF`.
  - Cycle 2: `ResultSrcM = 1`, `RegWriteM = 1`, `RD_M = 5`, `ALU_ResultM = 0x10`.
  - Required after edge 2: `ReadDataW = 0xDEADBEEF`, `RD_W = 5`, `RegWriteW = 1`, `ResultSrcW = 1`.
- **ALU pass-through:** `RegWriteM = 1`, `ResultSrcM = 0`, `ALU_ResultM = 0x00000008`, `RD_M = 3`, `PCPlus4M = 0x104`. Required next cycle: `ALU_ResultW = 0x8`, `RD_W = 3`, `PCPlus4W = 0x104`, `MisalignW = 0`.
- **Misaligned store:** store `0x11111111` to 0x20, then store `0x22222222` to 0x22, then load 0x20. Required: `ReadDataW = 0x11111111`, and `MisalignW = 1` on the cycle after the 0x22 store.
- **Misaligned load:** `ResultSrcM = 1`, `RegWriteM = 1`, `ALU_ResultM = 0x31`. Required next cycle: `RegWriteW = 0`, `MisalignW = 1`.
- **Wrap-around:** with `DEPTH = 1024`, store `0xCAFEF00D` to 0x1000, then load 0x0. Required: `ReadDataW = 0xCAFEF00D`.
- **Reset mid-operation:** assert `rst = 0` asynchronously mid-cycle during a store. Required: outputs clear immediately, and a load of that address after release returns the prior contents.
